// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: IF/ID-side instruction input and ID/RR-side micro-op output bundle
interface lmsm_sequencer_if;
    logic [15:0] in_ir;
    logic        in_valid;
    logic        stall_in;
    logic        flush;
    logic [15:0] out_ir;
    logic        out_valid;
    logic [2:0]  out_reg;
    logic [2:0]  out_offset;
    logic        out_last;
    logic        out_imm_zero;
    logic        hold;
    modport master (
        output in_ir, in_valid, stall_in, flush,
        input  out_ir, out_valid, out_reg, out_offset, out_last, out_imm_zero, hold
    );
    modport slave (
        input  in_ir, in_valid, stall_in, flush,
        output out_ir, out_valid, out_reg, out_offset, out_last, out_imm_zero, hold
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands LM/SM into one micro-op per selected register, passes others through
module lmsm_sequencer (
    input logic clk,
    input logic rst,
    lmsm_sequencer_if.slave bus
);
    typedef enum logic {IDLE, SEQ} state_t;
    state_t      state, state_n;
    logic [7:0]  rem, rem_n, m, nxt;
    logic [2:0]  cnt, cnt_n, b;
    logic [15:0] ir_q, ir_q_n, oir_n;
    logic [2:0]  oreg_n, ooff_n;
    logic        ov_n, olast_n, oz_n;
    logic        is_lmsm, active, multi;
    assign is_lmsm = bus.in_ir[15:13] == 3'b011;
    assign m       = (state == SEQ) ? rem : bus.in_ir[7:0];
    assign active  = (state == SEQ) || (bus.in_valid && is_lmsm);
    assign multi   = (m & (m - 8'd1)) != 8'd0;
    assign nxt     = m & ~(8'd1 << b);
    assign bus.hold = !rst && !bus.flush && (bus.stall_in || (active && multi));
    // highest set bit of the current mask (mask bit 7 is R0, so it goes first)
    always_comb begin
        b = 3'd0;
        for (int i = 0; i < 8; i++)
            if (m[i]) b = 3'(i);
    end
    // next state and next registered outputs; flush beats stall, stall freezes everything
    always_comb begin
        state_n = state;
        rem_n   = rem;
        cnt_n   = cnt;
        ir_q_n  = ir_q;
        oir_n   = bus.out_ir;
        ov_n    = bus.out_valid;
        oreg_n  = bus.out_reg;
        ooff_n  = bus.out_offset;
        olast_n = bus.out_last;
        oz_n    = bus.out_imm_zero;
        if (bus.flush) begin
            ov_n    = 1'b0;
            state_n = IDLE;
            rem_n   = 8'd0;
            cnt_n   = 3'd0;
        end else if (!bus.stall_in) begin
            if (state == SEQ) begin
                oir_n   = ir_q;
                ov_n    = 1'b1;
                oreg_n  = 3'd7 - b;
                ooff_n  = cnt;
                olast_n = nxt == 8'd0;
                oz_n    = 1'b0;
                rem_n   = nxt;
                cnt_n   = cnt + 3'd1;
                state_n = (nxt == 8'd0) ? IDLE : SEQ;
            end else if (!bus.in_valid) begin
                ov_n = 1'b0;
            end else begin
                oir_n   = bus.in_ir;
                ov_n    = 1'b1;
                oreg_n  = 3'd0;
                ooff_n  = 3'd0;
                olast_n = 1'b1;
                oz_n    = is_lmsm && (m == 8'd0);
                if (is_lmsm && m != 8'd0) begin
                    oreg_n  = 3'd7 - b;
                    olast_n = nxt == 8'd0;
                    if (nxt != 8'd0) begin
                        ir_q_n  = bus.in_ir;
                        rem_n   = nxt;
                        cnt_n   = 3'd1;
                        state_n = SEQ;
                    end
                end
            end
        end
    end
    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rem              <= 8'd0;
            cnt              <= 3'd0;
            ir_q             <= 16'h0000;
            bus.out_ir       <= 16'h0000;
            bus.out_valid    <= 1'b0;
            bus.out_reg      <= 3'd0;
            bus.out_offset   <= 3'd0;
            bus.out_last     <= 1'b0;
            bus.out_imm_zero <= 1'b0;
        end else begin
            state            <= state_n;
            rem              <= rem_n;
            cnt              <= cnt_n;
            ir_q             <= ir_q_n;
            bus.out_ir       <= oir_n;
            bus.out_valid    <= ov_n;
            bus.out_reg      <= oreg_n;
            bus.out_offset   <= ooff_n;
            bus.out_last     <= olast_n;
            bus.out_imm_zero <= oz_n;
        end
    end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed test-plan scenarios plus random traffic against a register-list model
module tb_lmsm_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    lmsm_sequencer_if bus();
    lmsm_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int failures = 0;
    int pend[$];
    int m_off;
    logic [15:0] m_ir, e_ir;
    logic [2:0]  e_reg, e_off;
    logic        e_valid, e_last, e_imm;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit lmsm(input logic [15:0] ir);
        return ir[15:13] == 3'b011;
    endfunction
    task automatic model_reset();
        pend.delete();
        m_off = 0;
        m_ir = 16'h0;
        e_ir = 16'h0;
        e_reg = 3'd0;
        e_off = 3'd0;
        e_valid = 1'b0;
        e_last = 1'b0;
        e_imm = 1'b0;
    endtask
    task automatic check_outputs(input string pfx);
        chk({pfx, "out_valid"}, 16'(bus.out_valid), 16'(e_valid));
        if (e_valid) begin
            chk({pfx, "out_ir"}, bus.out_ir, e_ir);
            chk({pfx, "out_reg"}, 16'(bus.out_reg), 16'(e_reg));
            chk({pfx, "out_offset"}, 16'(bus.out_offset), 16'(e_off));
            chk({pfx, "out_last"}, 16'(bus.out_last), 16'(e_last));
            chk({pfx, "out_imm_zero"}, 16'(bus.out_imm_zero), 16'(e_imm));
        end
    endtask
    task automatic cycle(input logic [15:0] ir, input logic v, input logic st, input logic fl);
        int regs[$];
        logic e_hold;
        bus.in_ir = ir;
        bus.in_valid = v;
        bus.stall_in = st;
        bus.flush = fl;
        #2;
        if (fl) e_hold = 1'b0;
        else if (st) e_hold = 1'b1;
        else if (pend.size() > 0) e_hold = pend.size() >= 2;
        else e_hold = v && lmsm(ir) && ($countones(ir[7:0]) >= 2);
        chk("hold", 16'(bus.hold), 16'(e_hold));
        @(posedge clk);
        if (fl) begin
            e_valid = 1'b0;
            pend.delete();
        end else if (!st) begin
            if (pend.size() > 0) begin
                e_ir = m_ir;
                e_valid = 1'b1;
                e_reg = 3'(pend.pop_front());
                m_off++;
                e_off = 3'(m_off);
                e_last = pend.size() == 0;
                e_imm = 1'b0;
            end else if (!v) begin
                e_valid = 1'b0;
            end else begin
                e_ir = ir;
                e_valid = 1'b1;
                e_reg = 3'd0;
                e_off = 3'd0;
                e_last = 1'b1;
                e_imm = 1'b0;
                m_off = 0;
                if (lmsm(ir)) begin
                    for (int r = 0; r < 8; r++)
                        if (ir[7 - r]) regs.push_back(r);
                    if (regs.size() == 0) e_imm = 1'b1;
                    else begin
                        e_reg = 3'(regs.pop_front());
                        e_last = regs.size() == 0;
                        pend = regs;
                        m_ir = ir;
                    end
                end
            end
        end
        #1;
        check_outputs("");
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(16'h0000, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic check_reset_state();
        chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_out_ir", bus.out_ir, 16'h0);
        chk("rst_out_reg", 16'(bus.out_reg), 16'h0);
        chk("rst_out_offset", 16'(bus.out_offset), 16'h0);
        chk("rst_out_last", 16'(bus.out_last), 16'h0);
        chk("rst_out_imm_zero", 16'(bus.out_imm_zero), 16'h0);
        chk("rst_hold", 16'(bus.hold), 16'h0);
    endtask
    initial begin
        logic [15:0] ir;
        bus.in_ir = 16'h0;
        bus.in_valid = 1'b0;
        bus.stall_in = 1'b1;
        bus.flush = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_reset_state();
        bus.stall_in = 1'b0;
        #11 rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(16'h0298, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(16'h62A1, 1'b1, 1'b0, 1'b0);
        chk("lm_first_reg", 16'(bus.out_reg), 16'd0);
        idle(1);
        chk("lm_second_reg", 16'(bus.out_reg), 16'd2);
        idle(1);
        chk("lm_third_reg", 16'(bus.out_reg), 16'd7);
        idle(1);
        cycle(16'h7200, 1'b1, 1'b0, 1'b0);
        chk("sm_zero_imm", 16'(bus.out_imm_zero), 16'd1);
        idle(1);
        cycle(16'h72FF, 1'b1, 1'b0, 1'b0);
        idle(7);
        chk("sm_ff_last_reg", 16'(bus.out_reg), 16'd7);
        idle(1);
        cycle(16'h62FF, 1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1, 1'b0);
        chk("stall_frozen_reg", 16'(bus.out_reg), 16'd2);
        idle(1);
        chk("resume_reg", 16'(bus.out_reg), 16'd3);
        idle(1);
        cycle(16'h0000, 1'b0, 1'b1, 1'b1);
        cycle(16'h0298, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(16'h63F0, 1'b1, 1'b0, 1'b0);
        idle(1);
        bus.stall_in = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_state();
        model_reset();
        bus.stall_in = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(16'h0298, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            ir = 16'($urandom);
            if ($urandom_range(1, 0) == 1) ir[15:13] = 3'b011;
            case ($urandom_range(7, 0))
                0: ir[7:0] = 8'h00;
                1: ir[7:0] = 8'hFF;
                default: ;
            endcase
            cycle(ir, $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, $urandom_range(15, 0) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
